// File: rtl/pwm_duty_ctrl_if.sv
// pwm_duty_ctrl_if: tick/button inputs and PWM/duty outputs of the duty controller
interface pwm_duty_ctrl_if #(parameter int PWM_W = 8);
  logic slow_clk;
  logic btn_up;
  logic btn_dn;
  logic pwm_out;
  logic [PWM_W-1:0] duty;
  logic at_max;
  logic at_min;
  modport master (output slow_clk, btn_up, btn_dn, input pwm_out, duty, at_max, at_min);
  modport slave (input slow_clk, btn_up, btn_dn, output pwm_out, duty, at_max, at_min);
endinterface

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounced up/down buttons with hold-to-repeat step a duty register driving a glitch-free PWM
module pwm_duty_ctrl #(
  parameter int PWM_W      = 8,
  parameter int DUTY_INIT  = 128,
  parameter int DUTY_STEP  = 16,
  parameter int DEB_TICKS  = 3,
  parameter int HOLD_TICKS = 50,
  parameter int REP_TICKS  = 10
) (
  input logic clk,
  input logic rst_n,
  pwm_duty_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REP_TICKS + 1);
  localparam logic [PWM_W:0] MAX = {1'b0, {PWM_W{1'b1}}};
  localparam logic [PWM_W:0] STEP = (PWM_W+1)'(DUTY_STEP);
  localparam logic [PWM_W-1:0] INIT = PWM_W'(DUTY_INIT);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2;
  logic slow_d, tick;
  logic [1:0] up_s, dn_s;
  logic deb_up, deb_dn;
  logic [DW-1:0] up_cnt, dn_cnt;
  logic cmd_up, cmd_dn, same, hold_done, rep_done, do_step, step_dir;
  logic [1:0] state;
  logic dir;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic [PWM_W-1:0] duty, duty_act, cnt, up_val, dn_val;
  logic [PWM_W:0] sum;
  logic pwm;
  assign tick = bus.slow_clk ^ slow_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slow_d <= 1'b0;
      up_s <= '0;
      dn_s <= '0;
    end else begin
      slow_d <= bus.slow_clk;
      up_s <= {up_s[0], bus.btn_up};
      dn_s <= {dn_s[0], bus.btn_dn};
    end
  // a level is accepted only after DEB_TICKS consecutive tick samples disagree with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deb_up <= 1'b0;
      deb_dn <= 1'b0;
      up_cnt <= '0;
      dn_cnt <= '0;
    end else if (tick) begin
      if (up_s[1] != deb_up) begin
        if (up_cnt == DW'(DEB_TICKS - 1)) begin
          deb_up <= up_s[1];
          up_cnt <= '0;
        end else up_cnt <= up_cnt + DW'(1);
      end else up_cnt <= '0;
      if (dn_s[1] != deb_dn) begin
        if (dn_cnt == DW'(DEB_TICKS - 1)) begin
          deb_dn <= dn_s[1];
          dn_cnt <= '0;
        end else dn_cnt <= dn_cnt + DW'(1);
      end else dn_cnt <= '0;
    end
  always_comb begin
    cmd_up = deb_up & ~deb_dn;
    cmd_dn = deb_dn & ~deb_up;
    same = dir ? cmd_up : cmd_dn;
    hold_done = hold_cnt == HW'(HOLD_TICKS - 1);
    rep_done = rep_cnt == RW'(REP_TICKS - 1);
    do_step = tick & ((state == IDLE) ? (cmd_up | cmd_dn) :
                      same & ((state == HOLD) ? hold_done : rep_done));
    step_dir = (state == IDLE) ? cmd_up : dir;
    sum = {1'b0, duty} + STEP;
    up_val = (sum > MAX) ? MAX[PWM_W-1:0] : sum[PWM_W-1:0];
    dn_val = ({1'b0, duty} < STEP) ? '0 : duty - STEP[PWM_W-1:0];
  end
  // a dropped or reversed command always returns to IDLE without stepping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= 1'b0;
      hold_cnt <= '0;
      rep_cnt <= '0;
    end else if (tick) begin
      case (state)
        IDLE:
          if (cmd_up | cmd_dn) begin
            state <= HOLD;
            dir <= cmd_up;
            hold_cnt <= '0;
          end
        HOLD:
          if (!same) state <= IDLE;
          else if (hold_done) begin
            state <= REPEAT;
            rep_cnt <= '0;
          end else hold_cnt <= hold_cnt + HW'(1);
        REPEAT:
          if (!same) state <= IDLE;
          else rep_cnt <= rep_done ? '0 : rep_cnt + RW'(1);
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) duty <= INIT;
    else if (do_step) duty <= step_dir ? up_val : dn_val;
  // the active duty is only reloaded on the last count so a period is never cut short
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      duty_act <= INIT;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      if (&cnt) duty_act <= duty;
      pwm <= cnt < duty_act;
    end
  assign bus.pwm_out = pwm;
  assign bus.duty = duty;
  assign bus.at_max = &duty;
  assign bus.at_min = ~|duty;
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: directed button sequences; a scoreboard checks every duty change and the tick it lands on
module tb_pwm_duty_ctrl;
  typedef struct {int duty; int tick;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slow_clk = 1'b0;
  int tick_no = 0;
  event tick_ev;
  int checks = 0;
  int errors = 0;
  int h0, h1, h2;
  int p;
  logic mon_en = 1'b0;
  logic [7:0] prev = 8'd128;
  exp_t sb[$];
  pwm_duty_ctrl_if #(.PWM_W(8)) b0 ();
  pwm_duty_ctrl_if #(.PWM_W(8)) b1 ();
  pwm_duty_ctrl_if #(.PWM_W(8)) b2 ();
  assign b0.slow_clk = slow_clk;
  assign b1.slow_clk = slow_clk;
  assign b2.slow_clk = slow_clk;
  pwm_duty_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  pwm_duty_ctrl #(.DUTY_INIT(250)) dut_hi (.clk(clk), .rst_n(rst_n), .bus(b1));
  pwm_duty_ctrl #(.DUTY_INIT(5)) dut_lo (.clk(clk), .rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;
  initial forever begin
    repeat (20) @(negedge clk);
    slow_clk = ~slow_clk;
    tick_no++;
    ->tick_ev;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) @(tick_ev);
  endtask
  task automatic push(input int d, input int t);
    exp_t e;
    e.duty = d;
    e.tick = t;
    sb.push_back(e);
  endtask
  task automatic settle();
    int w = 0;
    while (sb.size() != 0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask
  task automatic count_high(input int n);
    h0 = 0; h1 = 0; h2 = 0;
    repeat (n) begin
      @(negedge clk);
      h0 += int'(b0.pwm_out);
      h1 += int'(b1.pwm_out);
      h2 += int'(b2.pwm_out);
    end
  endtask
  task automatic pulse_after(input int exp);
    int t = 0;
    int len = 0;
    repeat (3) @(negedge clk);
    while (b0.pwm_out !== 1'b0 && t < 600) begin @(negedge clk); t++; end
    while (b0.pwm_out !== 1'b1 && t < 600) begin @(negedge clk); t++; end
    while (b0.pwm_out === 1'b1 && len < 600) begin len++; @(negedge clk); end
    chk("first_pulse_len", len, exp);
  endtask
  initial forever begin
    @(negedge clk);
    if (mon_en && b0.duty !== prev) begin
      if (sb.size() == 0) chk("unexpected_step", b0.duty, prev);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("duty", b0.duty, e.duty);
        if (e.tick >= 0) chk("step_tick", tick_no, e.tick);
        chk("at_max", b0.at_max, e.duty == 255);
        chk("at_min", b0.at_min, e.duty == 0);
      end
      prev = b0.duty;
    end
  end
  initial begin
    b0.btn_up = 0; b0.btn_dn = 0;
    b1.btn_up = 0; b1.btn_dn = 0;
    b2.btn_up = 0; b2.btn_dn = 0;
    repeat (3) @(negedge clk);
    chk("rst_duty", b0.duty, 128);
    chk("rst_pwm", b0.pwm_out, 0);
    chk("rst_at_max", b0.at_max, 0);
    chk("rst_at_min", b0.at_min, 0);
    chk("rst_duty_hi", b1.duty, 250);
    chk("rst_duty_lo", b2.duty, 5);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (300) @(negedge clk);
    count_high(256);
    chk("pwm_hi_128", h0, 128);
    chk("pwm_hi_250", h1, 250);
    chk("pwm_hi_5", h2, 5);
    // short glitch, then a 5-tick press giving exactly one step
    @(tick_ev);
    b0.btn_up = 1;
    ticks(2);
    b0.btn_up = 0;
    ticks(6);
    chk("short_pulse_ignored", b0.duty, 128);
    @(tick_ev);
    p = tick_no;
    push(144, p + 4);
    b0.btn_up = 1;
    ticks(4);
    fork
      pulse_after(144);
      begin ticks(1); b0.btn_up = 0; end
    join
    ticks(10);
    settle();
    count_high(256);
    chk("pwm_hi_144", h0, 144);
    // long down press: first step, auto-repeat after hold, then repeat period
    @(tick_ev);
    p = tick_no;
    push(128, p + 4);
    push(112, p + 54);
    push(96, p + 64);
    b0.btn_dn = 1;
    ticks(66);
    b0.btn_dn = 0;
    ticks(12);
    settle();
    count_high(256);
    chk("pwm_hi_96", h0, 96);
    // both buttons from IDLE, then a reversal during REPEAT
    @(tick_ev);
    b0.btn_up = 1; b0.btn_dn = 1;
    ticks(10);
    b0.btn_up = 0; b0.btn_dn = 0;
    ticks(6);
    chk("both_no_step", b0.duty, 96);
    @(tick_ev);
    p = tick_no;
    push(112, p + 4);
    push(128, p + 54);
    push(144, p + 64);
    b0.btn_up = 1;
    ticks(66);
    b0.btn_dn = 1;
    ticks(14);
    chk("reversal_frozen", b0.duty, 144);
    b0.btn_up = 0; b0.btn_dn = 0;
    ticks(6);
    settle();
    // saturation on the alternate-init instances
    @(tick_ev);
    b1.btn_up = 1; b2.btn_dn = 1;
    ticks(8);
    b1.btn_up = 0; b2.btn_dn = 0;
    chk("sat_max_duty", b1.duty, 255);
    chk("sat_max_flag", b1.at_max, 1);
    chk("sat_min_duty", b2.duty, 0);
    chk("sat_min_flag", b2.at_min, 1);
    chk("sat_min_notmax", b2.at_max, 0);
    ticks(15);
    count_high(512);
    chk("pwm_hi_255", h1, 510);
    chk("pwm_hi_0", h2, 0);
    // reset asserted mid-REPEAT between clock edges
    @(tick_ev);
    p = tick_no;
    push(160, p + 4);
    push(176, p + 54);
    push(192, p + 64);
    b0.btn_up = 1;
    ticks(67);
    settle();
    repeat (7) @(negedge clk);
    #3;
    push(128, -1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_duty", b0.duty, 128);
    chk("async_rst_pwm", b0.pwm_out, 0);
    chk("async_rst_at_max", b0.at_max, 0);
    chk("async_rst_at_min", b0.at_min, 0);
    b0.btn_up = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    ticks(10);
    chk("no_step_after_rst", b0.duty, 128);
    settle();
    @(tick_ev);
    p = tick_no;
    push(144, p + 4);
    b0.btn_up = 1;
    ticks(5);
    b0.btn_up = 0;
    ticks(10);
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
